// File: rtl/valu_sequencer.sv
// Vector ALU sequencer: runs one vector request through a shared scalar ALU,
// one enabled lane per cycle, and holds the per-lane results until they are consumed.
module valu_sequencer #(
  parameter int THREADS = 4,
  parameter int WORD_W  = 32,
  parameter int OP_W    = 4
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [OP_W-1:0]                 req_op,
  input  logic [THREADS-1:0]              req_mask,
  input  logic [THREADS-1:0][WORD_W-1:0]  req_porta,
  input  logic [THREADS-1:0][WORD_W-1:0]  req_portb,
  output logic [WORD_W-1:0]               alu_porta,
  output logic [WORD_W-1:0]               alu_portb,
  output logic [OP_W-1:0]                 alu_op,
  input  logic [WORD_W-1:0]               alu_out,
  input  logic                            alu_nf,
  input  logic                            alu_zf,
  input  logic                            alu_of,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [THREADS-1:0][WORD_W-1:0]  rsp_out,
  output logic [THREADS-1:0]              rsp_nf,
  output logic [THREADS-1:0]              rsp_zf,
  output logic [THREADS-1:0]              rsp_of,
  output logic                            busy
);

  localparam int IDX_W = (THREADS > 1) ? $clog2(THREADS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                           state_r;
  logic [IDX_W-1:0]                 lane_r;
  logic [OP_W-1:0]                  op_r;
  logic [THREADS-1:0]               mask_r;
  logic [THREADS-1:0][WORD_W-1:0]   porta_r;
  logic [THREADS-1:0][WORD_W-1:0]   portb_r;
  logic [THREADS-1:0][WORD_W-1:0]   rsp_out_r;
  logic [THREADS-1:0]               rsp_nf_r;
  logic [THREADS-1:0]               rsp_zf_r;
  logic [THREADS-1:0]               rsp_of_r;
  logic [WORD_W-1:0]                alu_porta_r;
  logic [WORD_W-1:0]                alu_portb_r;
  logic [OP_W-1:0]                  alu_op_r;
  logic                             req_ready_r;
  logic                             rsp_valid_r;
  logic                             busy_r;
  logic [IDX_W:0]                   first_s;
  logic [IDX_W:0]                   next_s;

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [IDX_W:0] find_lane(input logic [THREADS-1:0] m, input int from);
    logic [IDX_W:0] res;
    res = '0;
    for (int i = THREADS - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) begin
        res = {1'b1, IDX_W'(i)};
      end
    end
    return res;
  endfunction

  // Lane search for the incoming mask and for the step after the current lane.
  always_comb begin
    first_s = find_lane(req_mask, 0);
    next_s  = find_lane(mask_r, int'(lane_r) + 1);
  end

  // Sequencer state, operand latches, result slots and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= IDLE;
      lane_r      <= '0;
      op_r        <= '0;
      mask_r      <= '0;
      porta_r     <= '0;
      portb_r     <= '0;
      rsp_out_r   <= '0;
      rsp_nf_r    <= '0;
      rsp_zf_r    <= '0;
      rsp_of_r    <= '0;
      alu_porta_r <= '0;
      alu_portb_r <= '0;
      alu_op_r    <= '0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            op_r        <= req_op;
            mask_r      <= req_mask;
            porta_r     <= req_porta;
            portb_r     <= req_portb;
            rsp_out_r   <= '0;
            rsp_nf_r    <= '0;
            rsp_zf_r    <= '0;
            rsp_of_r    <= '0;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            rsp_valid_r <= 1'b0;
            if (first_s[IDX_W]) begin
              state_r     <= RUN;
              lane_r      <= first_s[IDX_W-1:0];
              alu_porta_r <= req_porta[first_s[IDX_W-1:0]];
              alu_portb_r <= req_portb[first_s[IDX_W-1:0]];
              alu_op_r    <= req_op;
            end else begin
              state_r <= DONE;
              lane_r  <= '0;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          rsp_out_r[lane_r] <= alu_out;
          rsp_nf_r[lane_r]  <= alu_nf;
          rsp_zf_r[lane_r]  <= alu_zf;
          rsp_of_r[lane_r]  <= alu_of;
          if (next_s[IDX_W]) begin
            lane_r      <= next_s[IDX_W-1:0];
            alu_porta_r <= porta_r[next_s[IDX_W-1:0]];
            alu_portb_r <= portb_r[next_s[IDX_W-1:0]];
            alu_op_r    <= op_r;
          end else begin
            state_r     <= DONE;
            alu_porta_r <= '0;
            alu_portb_r <= '0;
            alu_op_r    <= '0;
            rsp_valid_r <= 1'b1;
          end
        end
        DONE: begin
          // An empty mask enters DONE straight from IDLE; valid follows one cycle later.
          if (!rsp_valid_r) begin
            rsp_valid_r <= 1'b1;
          end else if (rsp_ready) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            req_ready_r <= 1'b1;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          alu_porta_r <= '0;
          alu_portb_r <= '0;
          alu_op_r    <= '0;
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign busy      = busy_r;
  assign alu_porta = alu_porta_r;
  assign alu_portb = alu_portb_r;
  assign alu_op    = alu_op_r;
  assign rsp_out   = rsp_out_r;
  assign rsp_nf    = rsp_nf_r;
  assign rsp_zf    = rsp_zf_r;
  assign rsp_of    = rsp_of_r;

endmodule

// File: tb/tb_valu_sequencer.sv
// Bench for valu_sequencer: directed scenarios plus randomized requests checked
// against a lane-list reference model; the scalar ALU is modelled here.
module tb_valu_sequencer;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b1;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic [3:0]           req_op = '0;
  logic [3:0]           req_mask = '0;
  logic [3:0][31:0]     req_porta = '0;
  logic [3:0][31:0]     req_portb = '0;
  logic [31:0]          alu_porta, alu_portb;
  logic [3:0]           alu_op;
  logic [31:0]          alu_out;
  logic                 alu_nf, alu_zf, alu_of;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [3:0][31:0]     rsp_out;
  logic [3:0]           rsp_nf, rsp_zf, rsp_of;
  logic                 busy;

  int checks = 0;
  int failures = 0;
  logic [3:0][31:0] exp_out;
  logic [3:0]       exp_nf, exp_zf, exp_of;

  valu_sequencer #(.THREADS(4), .WORD_W(32), .OP_W(4)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_mask(req_mask), .req_porta(req_porta), .req_portb(req_portb),
    .alu_porta(alu_porta), .alu_portb(alu_portb), .alu_op(alu_op),
    .alu_out(alu_out), .alu_nf(alu_nf), .alu_zf(alu_zf), .alu_of(alu_of),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
    .rsp_nf(rsp_nf), .rsp_zf(rsp_zf), .rsp_of(rsp_of), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Scalar ALU: 0 ADD, 1 SUB, 2 AND, 3 XOR.
  always_comb begin
    alu_out = 32'd0;
    alu_of  = 1'b0;
    case (alu_op)
      4'd0: begin alu_out = alu_porta + alu_portb;
                  alu_of  = (alu_porta[31] == alu_portb[31]) && (alu_out[31] != alu_porta[31]); end
      4'd1: begin alu_out = alu_porta - alu_portb;
                  alu_of  = (alu_porta[31] != alu_portb[31]) && (alu_out[31] != alu_porta[31]); end
      4'd2: alu_out = alu_porta & alu_portb;
      4'd3: alu_out = alu_porta ^ alu_portb;
      default: alu_out = 32'd0;
    endcase
    alu_nf = alu_out[31];
    alu_zf = (alu_out == 32'd0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected lane result {of, zf, nf, value} from signed integer arithmetic.
  function automatic logic [34:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, s;
    logic [31:0] r;
    logic o;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    o = 1'b0;
    r = 32'd0;
    s = 64'sd0;
    case (op)
      4'd0: begin s = sa + sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd1: begin s = sa - sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd2: r = a & b;
      4'd3: r = a ^ b;
      default: r = 32'd0;
    endcase
    return {o, (r == 32'd0), r[31], r};
  endfunction

  task automatic check_results(input string tag);
    for (int i = 0; i < 4; i++) chk($sformatf("%s_out%0d", tag, i), 64'(rsp_out[i]), 64'(exp_out[i]));
    chk({tag, "_nf"}, 64'(rsp_nf), 64'(exp_nf));
    chk({tag, "_zf"}, 64'(rsp_zf), 64'(exp_zf));
    chk({tag, "_of"}, 64'(rsp_of), 64'(exp_of));
  endtask

  // Offer a request (caller is just after a negedge) and follow it to DONE.
  task automatic issue(input logic [3:0] op, input logic [3:0] m,
                       input logic [3:0][31:0] a, input logic [3:0][31:0] b);
    int q[$];
    logic [34:0] r;
    for (int i = 0; i < 4; i++) begin
      exp_out[i] = 32'd0; exp_nf[i] = 1'b0; exp_zf[i] = 1'b0; exp_of[i] = 1'b0;
      if (m[i]) begin
        q.push_back(i);
        r = model(op, a[i], b[i]);
        exp_out[i] = r[31:0]; exp_nf[i] = r[32]; exp_zf[i] = r[33]; exp_of[i] = r[34];
      end
    end
    req_op = op; req_mask = m; req_porta = a; req_portb = b; req_valid = 1'b1;
    chk("req_ready_before_accept", 64'(req_ready), 64'd1);
    @(posedge CLK); #1;
    // Later changes on req_* and stray handshakes must not matter.
    req_valid = 1'($urandom_range(0, 1));
    req_op = 4'($urandom); req_mask = 4'($urandom);
    req_porta = {$urandom, $urandom, $urandom, $urandom};
    rsp_ready = (q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge CLK);
      chk($sformatf("run%0d_porta", i), 64'(alu_porta), 64'(a[q[i]]));
      chk($sformatf("run%0d_portb", i), 64'(alu_portb), 64'(b[q[i]]));
      chk($sformatf("run%0d_op", i), 64'(alu_op), 64'(op));
      chk($sformatf("run%0d_valid", i), 64'(rsp_valid), 64'd0);
      chk($sformatf("run%0d_busy", i), 64'(busy), 64'd1);
      if (i == q.size() - 1) rsp_ready = 1'b0;
    end
    if (q.size() == 0) begin
      @(negedge CLK);
      chk("empty_valid_early", 64'(rsp_valid), 64'd0);
      chk("empty_alu", 64'({alu_porta, alu_portb, alu_op} != 68'd0), 64'd0);
    end
    @(negedge CLK);
    chk("done_valid", 64'(rsp_valid), 64'd1);
    chk("done_req_ready", 64'(req_ready), 64'd0);
    chk("done_alu", 64'({alu_porta, alu_portb, alu_op} != 68'd0), 64'd0);
    check_results("done");
  endtask

  // Hold the response for 'hold' cycles, then consume it and confirm IDLE.
  task automatic consume(input int hold);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      check_results("hold");
    end
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
    @(negedge CLK);
    chk("idle_req_ready", 64'(req_ready), 64'd1);
    chk("idle_valid", 64'(rsp_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    @(negedge CLK);
    chk("no_queued_req", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [3:0][31:0] a, b;
    logic [31:0] hold_val;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_alu", 64'({alu_porta, alu_portb, alu_op} != 68'd0), 64'd0);
    chk("rst_out", 64'(rsp_out != 128'd0), 64'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Full-mask ADD
    a = {32'd4, 32'd3, 32'd2, 32'd1};
    b = {32'd40, 32'd30, 32'd20, 32'd10};
    issue(4'd0, 4'b1111, a, b);
    chk("s42_l0", 64'(rsp_out[0]), 64'd11);
    chk("s42_l3", 64'(rsp_out[3]), 64'd44);
    consume(1);

    // Sparse SUB with zero and overflow lanes
    a = {32'h80000000, 32'd9, 32'd7, 32'd5};
    b = {32'd1, 32'd1, 32'd7, 32'd5};
    issue(4'd1, 4'b1010, a, b);
    chk("s43_l1", 64'(rsp_out[1]), 64'd0);
    chk("s43_l1_zf", 64'(rsp_zf[1]), 64'd1);
    chk("s43_l3", 64'(rsp_out[3]), 64'h7FFFFFFF);
    chk("s43_l3_of", 64'(rsp_of[3]), 64'd1);
    chk("s43_l2", 64'(rsp_out[2]), 64'd0);
    consume(0);

    // Empty mask
    issue(4'd0, 4'b0000, a, b);
    consume(2);

    // Back-pressure with a pending request
    a = {32'd1, 32'd2, 32'd3, 32'd4};
    issue(4'd3, 4'b0110, a, b);
    hold_val = rsp_out[1];
    req_valid = 1'b1; req_op = 4'd0; req_mask = 4'b0001; req_porta = a; req_portb = b;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_stable", 64'(rsp_out[1]), 64'(hold_val));
    end
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
    @(negedge CLK);
    chk("bp_idle_ready", 64'(req_ready), 64'd1);
    issue(4'd0, 4'b0001, a, b);
    consume(0);

    // Reset in the second RUN cycle
    req_op = 4'd0; req_mask = 4'b1111; req_porta = a; req_portb = b; req_valid = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("s46_req_ready", 64'(req_ready), 64'd1);
    chk("s46_valid", 64'(rsp_valid), 64'd0);
    chk("s46_busy", 64'(busy), 64'd0);
    chk("s46_out", 64'(rsp_out != 128'd0), 64'd0);
    chk("s46_alu", 64'({alu_porta, alu_portb, alu_op} != 68'd0), 64'd0);
    issue(4'd0, 4'b1111, a, b);
    consume(0);

    // Randomized requests
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 4; i++) begin
        a[i] = $urandom; b[i] = $urandom;
        if ($urandom_range(0, 3) == 0) a[i] = 32'h80000000;
        if ($urandom_range(0, 3) == 0) b[i] = a[i];
      end
      issue(4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), a, b);
      consume($urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
